// File: rtl/wb_pkg.sv
// Shared definitions for the L2 write-buffer drain path.
//   WB_DATA_D_WTH / WB_DATA_A_WTH : default entry data / address widths
//   wb_drain_st_e                 : drain controller FSM states
//   wb_req_t                      : one buffered store (address + data)
package wb_pkg;

  localparam int WB_DATA_D_WTH = 8;
  localparam int WB_DATA_A_WTH = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } wb_drain_st_e;

  typedef struct packed {
    logic [WB_DATA_A_WTH-1:0] addr;
    logic [WB_DATA_D_WTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_ost_fifo.sv
// Outstanding-write address queue. Holds the address of every issued write
// in issue order so the responding write's address is always at the head.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : enqueue data_i (write accepted)
//   pop_i        : dequeue head (write response)
//   data_i       : address to enqueue
//   head_o       : oldest queued address
// The owner never pushes into a full queue or pops an empty one: both are
// bounded by its outstanding counter. Push and pop together are legal.
module wb_ost_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WTH   = WB_DATA_A_WTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [WTH-1:0] data_i,
  output logic [WTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  assign head_o = mem[rd_ptr];

endmodule

// File: rtl/wb_drain_ctrl.sv
// Write-buffer drain engine: pops buffered stores, issues them as memory
// write requests under an outstanding-write credit limit, records the
// address of the first erroring write, and offers a flush handshake.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   wb_*                : show-ahead write buffer read side
//   mem_wr_*            : write request channel (valid/ready)
//   mem_rsp_*           : in-order write responses
//   flush_i/flush_done_o: drain request pulse / completion pulse
//   busy_o, err_o, err_addr_o : status
//
// state | meaning
// RUN   | normal draining, waiting for a flush request
// FLUSH | draining, waiting for buffer, stage and in-flight writes to empty
// DONE  | one-cycle flush_done_o pulse, then back to RUN
module wb_drain_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_D_WTH = WB_DATA_D_WTH,
  parameter int DATA_A_WTH = WB_DATA_A_WTH,
  parameter int MAX_OST    = 4,
  parameter int OST_WTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_empty_i,
  input  logic [DATA_D_WTH-1:0] wb_rd_data_d_i,
  input  logic [DATA_A_WTH-1:0] wb_rd_data_a_i,
  output logic                  wb_rd_en_o,
  output logic                  mem_wr_valid_o,
  input  logic                  mem_wr_ready_i,
  output logic [DATA_A_WTH-1:0] mem_wr_addr_o,
  output logic [DATA_D_WTH-1:0] mem_wr_data_o,
  input  logic                  mem_rsp_valid_i,
  input  logic                  mem_rsp_err_i,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [DATA_A_WTH-1:0] err_addr_o
);

  logic                  stage_vld;
  logic [DATA_A_WTH-1:0] stage_addr;
  logic [DATA_D_WTH-1:0] stage_data;
  logic [OST_WTH-1:0]    ost_cnt;
  logic [OST_WTH:0]      credit_use;
  logic [DATA_A_WTH-1:0] head_addr;
  logic                  accept;
  logic                  rsp_take;
  logic                  ost_room;
  logic                  staged_keep;
  logic                  credit_ok;
  logic                  path_idle;
  wb_drain_st_e          state_q;
  wb_drain_st_e          state_d;

  // A staged entry is only presented while a credit is free, so the
  // in-flight count can never pass MAX_OST. Once presented, the count can
  // only rise through this entry's own accept, so valid never drops early.
  assign ost_room       = (ost_cnt < OST_WTH'(MAX_OST));
  assign mem_wr_valid_o = stage_vld & ost_room;
  assign accept         = mem_wr_valid_o & mem_wr_ready_i;

  assign staged_keep = stage_vld & ~accept;
  assign credit_use  = {1'b0, ost_cnt} + {{OST_WTH{1'b0}}, staged_keep};
  assign credit_ok   = (credit_use < (OST_WTH + 1)'(MAX_OST));

  // No pop during reset: the stage would not capture the entry.
  assign wb_rd_en_o = ~rst_i & ~wb_empty_i & (~stage_vld | accept) & credit_ok;

  // Responses with nothing in flight (e.g. stale ones after a reset) are dropped.
  assign rsp_take = mem_rsp_valid_i & (ost_cnt != '0);

  assign mem_wr_addr_o = stage_addr;
  assign mem_wr_data_o = stage_data;
  assign busy_o        = ~wb_empty_i | mem_wr_valid_o | (ost_cnt != '0);
  assign path_idle     = wb_empty_i & ~stage_vld & (ost_cnt == '0);
  assign flush_done_o  = (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_vld  <= 1'b0;
      stage_addr <= '0;
      stage_data <= '0;
    end else if (wb_rd_en_o) begin
      stage_vld  <= 1'b1;
      stage_addr <= wb_rd_data_a_i;
      stage_data <= wb_rd_data_d_i;
    end else if (accept) begin
      stage_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ost_cnt <= '0;
    end else begin
      case ({accept, rsp_take})
        2'b10:   ost_cnt <= ost_cnt + 1'b1;
        2'b01:   ost_cnt <= ost_cnt - 1'b1;
        default: ost_cnt <= ost_cnt;
      endcase
    end
  end

  wb_ost_fifo #(
    .DEPTH (MAX_OST),
    .WTH   (DATA_A_WTH)
  ) u_ost_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (accept),
    .pop_i  (rsp_take),
    .data_i (stage_addr),
    .head_o (head_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (rsp_take & mem_rsp_err_i & ~err_o) begin
      err_o      <= 1'b1;
      err_addr_o <= head_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_i) state_d = FLUSH;
      FLUSH:   if (path_idle) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Directed bench for wb_drain_ctrl. Inputs change and outputs are sampled
// around the falling edge; the write buffer is a simple array with a read
// pointer advanced on wb_rd_en_o.
module tb_wb_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_empty_i;
  logic [7:0]  wb_rd_data_d_i;
  logic [31:0] wb_rd_data_a_i;
  logic        wb_rd_en_o;
  logic        mem_wr_valid_o;
  logic        mem_wr_ready_i = 1'b0;
  logic [31:0] mem_wr_addr_o;
  logic [7:0]  mem_wr_data_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic        mem_rsp_err_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        flush_done_o;
  logic        busy_o;
  logic        err_o;
  logic [31:0] err_addr_o;

  always #5 clk = ~clk;

  wb_drain_ctrl #(
    .DATA_D_WTH (8),
    .DATA_A_WTH (32),
    .MAX_OST    (4),
    .OST_WTH    (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .wb_empty_i      (wb_empty_i),
    .wb_rd_data_d_i  (wb_rd_data_d_i),
    .wb_rd_data_a_i  (wb_rd_data_a_i),
    .wb_rd_en_o      (wb_rd_en_o),
    .mem_wr_valid_o  (mem_wr_valid_o),
    .mem_wr_ready_i  (mem_wr_ready_i),
    .mem_wr_addr_o   (mem_wr_addr_o),
    .mem_wr_data_o   (mem_wr_data_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .flush_i         (flush_i),
    .flush_done_o    (flush_done_o),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .err_addr_o      (err_addr_o)
  );

  // write buffer model
  logic [31:0] wb_a [64];
  logic [7:0]  wb_d [64];
  logic [5:0]  wb_rd = '0;
  logic [5:0]  wb_wr = '0;

  assign wb_empty_i     = (wb_rd == wb_wr);
  assign wb_rd_data_a_i = wb_a[wb_rd];
  assign wb_rd_data_d_i = wb_d[wb_rd];

  // monitors
  int pop_cnt = 0;
  int acc_cnt = 0;
  int fd_cnt = 0;
  int cyc = 0;
  int last_rsp_cyc = 0;
  int fd_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wb_rd_en_o) begin
      wb_rd   <= wb_rd + 1'b1;
      pop_cnt <= pop_cnt + 1;
    end
    if (mem_wr_valid_o && mem_wr_ready_i) acc_cnt <= acc_cnt + 1;
    if (mem_rsp_valid_i) last_rsp_cyc <= cyc;
    if (flush_done_o) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // auto responder: one in-order response per cycle while writes are pending
  bit auto_rsp = 1'b0;
  int rsp_cnt = 0;
  int err_lo = 1000000;
  int err_hi = -1;

  task automatic tick();
    @(negedge clk);
    if (auto_rsp) begin
      if (acc_cnt > rsp_cnt) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_err_i   = (rsp_cnt >= err_lo) && (rsp_cnt <= err_hi);
        rsp_cnt++;
      end else begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
      end
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      settle();
    end
  endtask

  task automatic push_wb(input logic [31:0] a, input logic [7:0] d);
    wb_a[wb_wr] = a;
    wb_d[wb_wr] = d;
    wb_wr = wb_wr + 1'b1;
  endtask

  int p0, a0, f0;

  // test 1 vectors, one per cycle starting with the push cycle
  logic        t1_rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        t1_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] t1_a  [5] = '{32'h0, 32'h100, 32'h104, 32'h108, 32'h0};
  logic [7:0]  t1_d  [5] = '{8'h0, 8'h11, 8'h22, 8'h33, 8'h0};

  initial begin
    // reset
    run(2);
    tick();
    rst_i = 1'b0;
    settle();
    chk("rst_valid", {31'b0, mem_wr_valid_o}, 32'd0);
    chk("rst_rd_en", {31'b0, wb_rd_en_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, flush_done_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_err_addr", err_addr_o, 32'd0);
    chk("rst_addr", mem_wr_addr_o, 32'd0);

    // 1: back-to-back issue with immediate responses
    auto_rsp = 1'b1;
    mem_wr_ready_i = 1'b1;
    p0 = pop_cnt; a0 = acc_cnt;
    tick();
    push_wb(32'h100, 8'h11);
    push_wb(32'h104, 8'h22);
    push_wb(32'h108, 8'h33);
    settle();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        settle();
      end
      chk($sformatf("t1_rd%0d", k), {31'b0, wb_rd_en_o}, {31'b0, t1_rd[k]});
      chk($sformatf("t1_v%0d", k), {31'b0, mem_wr_valid_o}, {31'b0, t1_v[k]});
      if (t1_v[k]) begin
        chk($sformatf("t1_a%0d", k), mem_wr_addr_o, t1_a[k]);
        chk($sformatf("t1_d%0d", k), {24'b0, mem_wr_data_o}, {24'b0, t1_d[k]});
      end
    end
    run(1);
    chk("t1_busy", {31'b0, busy_o}, 32'd0);
    chk("t1_pops", pop_cnt - p0, 32'd3);
    chk("t1_accepts", acc_cnt - a0, 32'd3);

    // 2: backpressure holds the staged request
    p0 = pop_cnt;
    tick();
    mem_wr_ready_i = 1'b0;
    push_wb(32'h100, 8'h11);
    push_wb(32'h104, 8'h22);
    settle();
    chk("t2_rd0", {31'b0, wb_rd_en_o}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      settle();
      chk($sformatf("t2_v%0d", k), {31'b0, mem_wr_valid_o}, 32'd1);
      chk($sformatf("t2_a%0d", k), mem_wr_addr_o, 32'h100);
      chk($sformatf("t2_d%0d", k), {24'b0, mem_wr_data_o}, 32'h11);
      chk($sformatf("t2_rd%0d", k), {31'b0, wb_rd_en_o}, 32'd0);
    end
    chk("t2_pops_held", pop_cnt - p0, 32'd1);
    tick();
    mem_wr_ready_i = 1'b1;
    settle();
    chk("t2_acc_a", mem_wr_addr_o, 32'h100);
    chk("t2_acc_rd", {31'b0, wb_rd_en_o}, 32'd1);
    tick();
    settle();
    chk("t2_next_v", {31'b0, mem_wr_valid_o}, 32'd1);
    chk("t2_next_a", mem_wr_addr_o, 32'h104);
    chk("t2_next_d", {24'b0, mem_wr_data_o}, 32'h22);
    run(4);
    chk("t2_busy", {31'b0, busy_o}, 32'd0);

    // 3: credit limit of 4 with no responses
    auto_rsp = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i = 1'b0;
    p0 = pop_cnt; a0 = acc_cnt;
    tick();
    for (int i = 0; i < 6; i++) push_wb(32'h300 + 32'(4 * i), 8'h60 + 8'(i));
    settle();
    run(10);
    chk("t3_accepts", acc_cnt - a0, 32'd4);
    chk("t3_pops", pop_cnt - p0, 32'd5);
    chk("t3_v_blocked", {31'b0, mem_wr_valid_o}, 32'd0);
    chk("t3_rd_stop", {31'b0, wb_rd_en_o}, 32'd0);
    chk("t3_busy", {31'b0, busy_o}, 32'd1);
    tick();
    mem_rsp_valid_i = 1'b1;
    rsp_cnt++;
    settle();
    tick();
    mem_rsp_valid_i = 1'b0;
    settle();
    chk("t3_resume_v", {31'b0, mem_wr_valid_o}, 32'd1);
    chk("t3_resume_a", mem_wr_addr_o, 32'h310);
    chk("t3_resume_d", {24'b0, mem_wr_data_o}, 32'h64);
    run(1);
    chk("t3_accepts5", acc_cnt - a0, 32'd5);
    auto_rsp = 1'b1;
    run(15);
    chk("t3_accepts6", acc_cnt - a0, 32'd6);
    chk("t3_pops6", pop_cnt - p0, 32'd6);
    chk("t3_drained", {31'b0, busy_o}, 32'd0);

    // 4: first error address is kept
    chk("t4_err_pre", {31'b0, err_o}, 32'd0);
    err_lo = rsp_cnt + 1;
    err_hi = rsp_cnt + 2;
    tick();
    push_wb(32'h200, 8'h01);
    push_wb(32'h204, 8'h02);
    push_wb(32'h208, 8'h03);
    settle();
    run(10);
    err_lo = 1000000;
    err_hi = -1;
    chk("t4_err", {31'b0, err_o}, 32'd1);
    chk("t4_err_addr", err_addr_o, 32'h204);

    // 5: flush with buffered and outstanding writes
    auto_rsp = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i = 1'b0;
    tick();
    push_wb(32'h400, 8'h44);
    settle();
    a0 = acc_cnt;
    run(3);
    chk("t5_ost1", acc_cnt - a0, 32'd1);
    f0 = fd_cnt;
    tick();
    push_wb(32'h404, 8'h45);
    push_wb(32'h408, 8'h46);
    flush_i = 1'b1;
    settle();
    tick();
    flush_i = 1'b0;
    settle();
    run(3);
    tick();
    flush_i = 1'b1;
    settle();
    tick();
    flush_i = 1'b0;
    settle();
    run(3);
    chk("t5_no_early_done", fd_cnt - f0, 32'd0);
    chk("t5_busy", {31'b0, busy_o}, 32'd1);
    auto_rsp = 1'b1;
    run(12);
    chk("t5_one_pulse", fd_cnt - f0, 32'd1);
    chk("t5_done_after_rsp", fd_cyc - last_rsp_cyc, 32'd2);
    chk("t5_idle", {31'b0, busy_o}, 32'd0);
    chk("t5_err_kept", err_addr_o, 32'h204);

    // idle flush: pulse two cycles after the request
    tick();
    flush_i = 1'b1;
    settle();
    tick();
    flush_i = 1'b0;
    settle();
    chk("t5_idle_c1", {31'b0, flush_done_o}, 32'd0);
    tick();
    settle();
    chk("t5_idle_c2", {31'b0, flush_done_o}, 32'd1);
    tick();
    settle();
    chk("t5_idle_c3", {31'b0, flush_done_o}, 32'd0);

    // 6: reset with 2 outstanding and one staged
    auto_rsp = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i = 1'b0;
    tick();
    push_wb(32'h500, 8'h50);
    push_wb(32'h504, 8'h51);
    push_wb(32'h508, 8'h52);
    settle();
    run(2);
    tick();
    mem_wr_ready_i = 1'b0;
    settle();
    chk("t6_staged_v", {31'b0, mem_wr_valid_o}, 32'd1);
    chk("t6_staged_a", mem_wr_addr_o, 32'h508);
    tick();
    rst_i = 1'b1;
    settle();
    tick();
    rst_i = 1'b0;
    settle();
    chk("t6_valid", {31'b0, mem_wr_valid_o}, 32'd0);
    chk("t6_addr", mem_wr_addr_o, 32'd0);
    chk("t6_data", {24'b0, mem_wr_data_o}, 32'd0);
    chk("t6_busy", {31'b0, busy_o}, 32'd0);
    chk("t6_err", {31'b0, err_o}, 32'd0);
    chk("t6_err_addr", err_addr_o, 32'd0);
    chk("t6_done", {31'b0, flush_done_o}, 32'd0);
    chk("t6_rd_en", {31'b0, wb_rd_en_o}, 32'd0);
    tick();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_err_i = 1'b1;
    settle();
    tick();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i = 1'b0;
    settle();
    chk("t6_stray_err", {31'b0, err_o}, 32'd0);
    chk("t6_stray_busy", {31'b0, busy_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
